// File: rtl/lock_pkg.sv
// Shared types and default constants for the digital-lock attempt controller.
// The ALARM state is only reachable when the design is built with LOCK_ALARM_EN.
package lock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2,
    ALARM   = 2'd3
  } lock_state_e;

  localparam int MAX_TRIES_DEF     = 3;
  localparam int UNLOCK_CYCLES_DEF = 8;
  localparam int LOCKOUT_LIMIT_DEF = 2;

  // Width of a counter that must be able to hold the value n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lock_hold_timer.sv
// Loadable down-counter that times the unlock hold window.
// expire is high in the last cycle of the window; busy covers the whole window.
module lock_hold_timer
  import lock_pkg::*;
#(
  parameter int CYCLES = UNLOCK_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic busy,
  output logic expire
);

  localparam int CW = cnt_width(CYCLES);

  logic [CW-1:0] r_count;
  logic          r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_busy  <= 1'b0;
    end else if (load) begin
      r_count <= CW'(CYCLES - 1);
      r_busy  <= 1'b1;
    end else if (r_busy) begin
      if (r_count == '0) begin
        r_busy <= 1'b0;
      end else begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  assign busy   = r_busy;
  assign expire = r_busy && (r_count == '0);

endmodule

// File: rtl/lock_attempt_ctrl.sv
// Code-entry supervisor: timed unlock, wrong-code counting and countdown lockout.
// Build with LOCK_ALARM_EN to add the sticky ALARM state after repeated lockouts.
module lock_attempt_ctrl
  import lock_pkg::*;
#(
  parameter int MAX_TRIES     = MAX_TRIES_DEF,
  parameter int UNLOCK_CYCLES = UNLOCK_CYCLES_DEF,
  parameter int LOCKOUT_LIMIT = LOCKOUT_LIMIT_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          code_valid,
  input  logic                          code_match,
  input  logic                          cd_done,
  output logic                          cd_start,
  output logic                          unlock,
  output logic                          lockout,
  output logic [$clog2(MAX_TRIES+1)-1:0] fail_cnt,
  output logic                          alarm
);

  localparam int FW = $clog2(MAX_TRIES + 1);

  lock_state_e   r_state;
  lock_state_e   w_state_next;
  logic [FW-1:0] r_fail;
  logic [FW-1:0] w_fail_next;
  logic          r_cd_start;
  logic          w_cd_start_next;
  logic          r_unlock;
  logic          r_lockout;
  logic          w_load;
  logic          w_busy;
  logic          w_expire;

`ifdef LOCK_ALARM_EN
  localparam int LW = cnt_width(LOCKOUT_LIMIT);

  logic [LW-1:0] r_lock_cnt;
  logic [LW-1:0] w_lock_cnt_next;
  logic [LW-1:0] w_lock_cnt_inc;
  logic          r_alarm;

  assign w_lock_cnt_inc = (r_lock_cnt == LW'(LOCKOUT_LIMIT)) ? r_lock_cnt
                                                             : r_lock_cnt + LW'(1);
`endif

  lock_hold_timer #(
    .CYCLES (UNLOCK_CYCLES)
  ) u_hold_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (w_load),
    .busy   (w_busy),
    .expire (w_expire)
  );

  always_comb begin
    w_state_next    = r_state;
    w_fail_next     = r_fail;
    w_cd_start_next = 1'b0;
    w_load          = 1'b0;
`ifdef LOCK_ALARM_EN
    w_lock_cnt_next = r_lock_cnt;
`endif
    case (r_state)
      IDLE: begin
        if (code_valid) begin
          if (code_match) begin
            w_state_next = OPEN;
            w_fail_next  = '0;
            w_load       = 1'b1;
`ifdef LOCK_ALARM_EN
            w_lock_cnt_next = '0;
`endif
          end else if (int'(r_fail) + 1 < MAX_TRIES) begin
            w_fail_next = r_fail + FW'(1);
          end else begin
            w_fail_next = '0;
`ifdef LOCK_ALARM_EN
            w_lock_cnt_next = w_lock_cnt_inc;
            if (w_lock_cnt_inc == LW'(LOCKOUT_LIMIT)) begin
              w_state_next = ALARM;
            end else begin
              w_state_next    = LOCKOUT;
              w_cd_start_next = 1'b1;
            end
`else
            w_state_next    = LOCKOUT;
            w_cd_start_next = 1'b1;
`endif
          end
        end
      end
      OPEN: begin
        if (w_expire || !w_busy) begin
          w_state_next = IDLE;
        end
      end
      LOCKOUT: begin
        // r_cd_start marks the first lockout cycle, where cd_done may still be stale.
        if (!r_cd_start && cd_done) begin
          w_state_next = IDLE;
        end
      end
      default: begin
`ifndef LOCK_ALARM_EN
        w_state_next = IDLE;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_fail     <= '0;
      r_cd_start <= 1'b0;
      r_unlock   <= 1'b0;
      r_lockout  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_fail     <= w_fail_next;
      r_cd_start <= w_cd_start_next;
      r_unlock   <= (w_state_next == OPEN);
      r_lockout  <= (w_state_next == LOCKOUT) || (w_state_next == ALARM);
    end
  end

`ifdef LOCK_ALARM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_cnt <= '0;
      r_alarm    <= 1'b0;
    end else begin
      r_lock_cnt <= w_lock_cnt_next;
      r_alarm    <= (w_state_next == ALARM);
    end
  end

  assign alarm = r_alarm;
`else
  assign alarm = 1'b0;
`endif

  assign cd_start = r_cd_start;
  assign unlock   = r_unlock;
  assign lockout  = r_lockout;
  assign fail_cnt = r_fail;

endmodule
